// File: rtl/cim_scan_responder_if.sv
// Scan-protocol bundle between the harness (master) and the CIM scan responder (slave).
//   i_scan_in      serial frame data, LSB first
//   i_se           scan enable, shift while high
//   i_update       single-cycle commit strobe
//   i_capture      single-cycle capture strobe
//   i_capture_data parallel CIM result sampled on capture
//   o_scan_out     registered serial output, MSB of output chain first
//   o_update_data  shadow register (last committed frame)
//   o_update_valid one-cycle pulse when the shadow register loads
//   o_shift_count  saturating shift counter since last update/capture
//   o_frame_done   one-cycle pulse when the count reaches SCAN_IN_WIDTH
//   o_err          sticky protocol error
//   o_state        FSM state: 0=IDLE, 1=SHIFT, 2=COMMIT
interface cim_scan_responder_if #(
    parameter int unsigned SCAN_IN_WIDTH  = 128,
    parameter int unsigned SCAN_OUT_WIDTH = 129,
    parameter int unsigned CNT_W          = $clog2(SCAN_IN_WIDTH + 2)
);
    logic                      i_scan_in;
    logic                      i_se;
    logic                      i_update;
    logic                      i_capture;
    logic [SCAN_OUT_WIDTH-1:0] i_capture_data;
    logic                      o_scan_out;
    logic [SCAN_IN_WIDTH-1:0]  o_update_data;
    logic                      o_update_valid;
    logic [CNT_W-1:0]          o_shift_count;
    logic                      o_frame_done;
    logic                      o_err;
    logic [1:0]                o_state;

    modport master (
        output i_scan_in, i_se, i_update, i_capture, i_capture_data,
        input  o_scan_out, o_update_data, o_update_valid, o_shift_count,
               o_frame_done, o_err, o_state
    );

    modport slave (
        input  i_scan_in, i_se, i_update, i_capture, i_capture_data,
        output o_scan_out, o_update_data, o_update_valid, o_shift_count,
               o_frame_done, o_err, o_state
    );
endinterface

// File: rtl/cim_scan_responder.sv
// CIM-side scan chain responder: shifts serial frames into a capture register,
// commits full frames to a shadow register on update, and serializes parallel
// CIM results (loaded on capture) out MSB first.
//   i_har_clk    single clock, all activity on the rising edge
//   i_har_reset  asynchronous active-high reset
//   bus          scan protocol bundle (slave side), see cim_scan_responder_if
module cim_scan_responder #(
    parameter int unsigned SCAN_IN_WIDTH  = 128,
    parameter int unsigned SCAN_OUT_WIDTH = 129,
    parameter int unsigned CNT_W          = $clog2(SCAN_IN_WIDTH + 2)
) (
    input  logic                 i_har_clk,
    input  logic                 i_har_reset,
    cim_scan_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SCAN_IN_WIDTH);
    localparam logic [CNT_W-1:0] PRE_FULL = CNT_W'(SCAN_IN_WIDTH - 1);

    state_t                    state;
    state_t                    state_next;
    logic [SCAN_IN_WIDTH-1:0]  in_sreg;
    logic [SCAN_OUT_WIDTH-1:0] out_sreg;
    logic [SCAN_IN_WIDTH-1:0]  shadow;
    logic [CNT_W-1:0]          count;
    logic                      scan_out;
    logic                      update_valid;
    logic                      frame_done;
    logic                      err;

    always_ff @(posedge i_har_clk or posedge i_har_reset) begin
        if (i_har_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.i_se) begin
                    state_next = SHIFT;
                end else if (bus.i_update) begin
                    state_next = COMMIT;
                end
            end
            SHIFT: begin
                if (!bus.i_se) begin
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                state_next = bus.i_se ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath reacts to i_se / strobes in every state; the FSM only tracks phase.
    always_ff @(posedge i_har_clk or posedge i_har_reset) begin
        if (i_har_reset) begin
            in_sreg      <= '0;
            out_sreg     <= '0;
            shadow       <= '0;
            count        <= '0;
            scan_out     <= 1'b0;
            update_valid <= 1'b0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            update_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (bus.i_se) begin
                in_sreg  <= {bus.i_scan_in, in_sreg[SCAN_IN_WIDTH-1:1]};
                out_sreg <= {out_sreg[SCAN_OUT_WIDTH-2:0], 1'b0};
                // Register the post-shift MSB so o_scan_out always mirrors the
                // head of the output chain: bit n is visible after shift edge n.
                scan_out <= out_sreg[SCAN_OUT_WIDTH-2];
                if (count != '1) begin
                    count <= count + 1'b1;
                end
                // Only the step W-1 -> W pulses; saturation past W never re-enters it.
                if (count == PRE_FULL) begin
                    frame_done <= 1'b1;
                end
                if (bus.i_update || bus.i_capture) begin
                    err <= 1'b1;
                end
            end else begin
                if (bus.i_update) begin
                    if (count == FULL_CNT) begin
                        shadow       <= in_sreg;
                        update_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    count <= '0;
                end
                if (bus.i_capture) begin
                    out_sreg <= bus.i_capture_data;
                    scan_out <= bus.i_capture_data[SCAN_OUT_WIDTH-1];
                    count    <= '0;
                end
            end
        end
    end

    assign bus.o_scan_out     = scan_out;
    assign bus.o_update_data  = shadow;
    assign bus.o_update_valid = update_valid;
    assign bus.o_shift_count  = count;
    assign bus.o_frame_done   = frame_done;
    assign bus.o_err          = err;
    assign bus.o_state        = state;

endmodule
